// File: rtl/pow_5_pipe_sched.sv
// Round-robin scheduler sharing one pipelined fifth-power datapath among N
// requesters. A tag pipeline mirrors the datapath so each result is steered
// back to the requester that issued it. A stalled result at the tail freezes
// the datapath and the tag pipeline together.
module pow_5_pipe_sched #(
  parameter int w   = 8,
  parameter int N   = 4,
  parameter int LAT = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_vld,
  input  logic [N*w-1:0] req_arg,
  output logic [N-1:0]   req_rdy,
  output logic [N-1:0]   res_vld,
  output logic [w-1:0]   res,
  input  logic [N-1:0]   res_rdy,
  output logic           pipe_clk_en,
  output logic           pipe_arg_vld,
  output logic [w-1:0]   pipe_arg,
  input  logic           pipe_res_vld,
  input  logic [w-1:0]   pipe_res,
  output logic           busy,
  output logic           err
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // tag pipeline: stage LAT-1 lines up with the datapath's final stage
  logic [LAT-1:0]         vld_pipe;
  logic [LAT-1:0][IW-1:0] id_pipe;
  logic [IW-1:0]          ptr;

  logic          tail_vld;
  logic [IW-1:0] tail_id;
  logic          pipe_en;
  logic          win_found;
  logic [IW-1:0] win_id;
  logic          grant;
  logic [w-1:0]  arg_arr [N];

  // split the flat argument bus into one slot per requester
  for (genvar i = 0; i < N; i++) begin : g_arg
    assign arg_arr[i] = req_arg[i*w +: w];
  end

  assign tail_vld = vld_pipe[LAT-1];
  assign tail_id  = id_pipe[LAT-1];

  // only an unaccepted result at the tail can stall; other owners' ready is ignored
  assign pipe_en     = ~(tail_vld & ~res_rdy[tail_id]);
  assign pipe_clk_en = pipe_en;

  // first pending requester at or after ptr, wrapping modulo N
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_v;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 0; k < N; k++) begin
      idx   = (int'(ptr) + k) % N;
      idx_v = IW'(idx);
      if (!win_found && req_vld[idx_v]) begin
        win_found = 1'b1;
        win_id    = idx_v;
      end
    end
  end

  assign grant        = pipe_en & ~rst & win_found;
  assign req_rdy      = grant ? (N'(1) << win_id) : '0;
  assign pipe_arg_vld = grant;
  assign pipe_arg     = grant ? arg_arr[win_id] : '0;

  assign res_vld = tail_vld ? (N'(1) << tail_id) : '0;
  assign res     = tail_vld ? pipe_res : '0;
  assign busy    = |vld_pipe;

  // advance tags in lockstep with the datapath; an idle cycle inserts a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else if (pipe_en) begin
      vld_pipe[0] <= grant;
      id_pipe[0]  <= grant ? win_id : '0;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  // round-robin pointer moves just past the last winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (grant)
      ptr <= (win_id == IW'(N-1)) ? '0 : win_id + 1'b1;
  end

  // sticky flag when the datapath's valid disagrees with our tag tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (pipe_res_vld != tail_vld)
      err <= 1'b1;
  end
endmodule

// File: tb/tb_pow_5_pipe_sched.sv
// Bench for pow_5_pipe_sched: a small datapath model feeds the DUT, and a
// queue-based scoreboard predicts grants, stalls and result delivery.
module tb_pow_5_pipe_sched;
  localparam int W   = 8;
  localparam int N   = 4;
  localparam int LAT = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_vld = '0;
  logic [N*W-1:0] req_arg = '0;
  logic [N-1:0]   req_rdy;
  logic [N-1:0]   res_vld;
  logic [W-1:0]   res;
  logic [N-1:0]   res_rdy = '1;
  logic           pipe_clk_en;
  logic           pipe_arg_vld;
  logic [W-1:0]   pipe_arg;
  logic           pipe_res_vld;
  logic [W-1:0]   pipe_res;
  logic           busy;
  logic           err;
  logic           force_vld = 1'b0;

  pow_5_pipe_sched #(.w(W), .N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_arg(req_arg), .req_rdy(req_rdy),
    .res_vld(res_vld), .res(res), .res_rdy(res_rdy),
    .pipe_clk_en(pipe_clk_en), .pipe_arg_vld(pipe_arg_vld), .pipe_arg(pipe_arg),
    .pipe_res_vld(pipe_res_vld), .pipe_res(pipe_res),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pow5(input logic [W-1:0] a);
    longint x;
    x = longint'(a);
    return W'(x * x * x * x * x);
  endfunction

  // datapath stand-in: LAT enabled stages computing arg^5
  logic [LAT-1:0] dp_vld;
  logic [W-1:0]   dp_val [LAT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_vld <= '0;
      for (int i = 0; i < LAT; i++) dp_val[i] <= '0;
    end else if (pipe_clk_en) begin
      dp_vld[0] <= pipe_arg_vld;
      dp_val[0] <= pow5(pipe_arg);
      for (int i = 1; i < LAT; i++) begin
        dp_vld[i] <= dp_vld[i-1];
        dp_val[i] <= dp_val[i-1];
      end
    end
  end
  assign pipe_res_vld = dp_vld[LAT-1] | force_vld;
  assign pipe_res     = dp_val[LAT-1];

  // scoreboard: in-flight ops in issue order, age = enabled edges since issue
  typedef struct {int id; int val; int age;} op_t;
  op_t q[$];
  int  exp_ptr = 0;
  bit  err_exp = 1'b0;
  int  n_chk = 0;
  int  n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [N*W-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    logic [N*W-1:0] v;
    v = '0;
    v[0*W +: W] = W'(a0);
    v[1*W +: W] = W'(a1);
    v[2*W +: W] = W'(a2);
    v[3*W +: W] = W'(a3);
    return v;
  endfunction

  // one cycle: drive at edge+1, check at edge+2, advance model, wait for next edge+1
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a,
                      input logic [N-1:0] r, input logic fv);
    bit   tail, stall;
    int   win;
    op_t  op;
    req_vld = v; req_arg = a; res_rdy = r; force_vld = fv;
    #1;
    tail  = (q.size() > 0) && (q[0].age == LAT);
    stall = tail && !r[q[0].id];
    win   = -1;
    if (!stall)
      for (int k = 0; k < N; k++)
        if (win < 0 && v[(exp_ptr + k) % N]) win = (exp_ptr + k) % N;
    chk("req_rdy",  req_rdy, (win >= 0) ? (1 << win) : 0);
    chk("clk_en",   pipe_clk_en, !stall);
    chk("arg_vld",  pipe_arg_vld, win >= 0);
    chk("pipe_arg", pipe_arg, (win >= 0) ? a[win*W +: W] : 0);
    chk("res_vld",  res_vld, tail ? (1 << q[0].id) : 0);
    chk("res",      res, tail ? q[0].val : 0);
    chk("busy",     busy, q.size() > 0);
    chk("err",      err, err_exp);
    if (fv && !tail) err_exp = 1'b1;
    if (!stall) begin
      if (tail) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (win >= 0) begin
        op.id = win; op.val = int'(pow5(a[win*W +: W])); op.age = 1;
        q.push_back(op);
        exp_ptr = (win + 1) % N;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic rst_checks(input string pfx);
    chk({pfx, "_busy"},    busy, 0);
    chk({pfx, "_res_vld"}, res_vld, 0);
    chk({pfx, "_res"},     res, 0);
    chk({pfx, "_err"},     err, 0);
    chk({pfx, "_req_rdy"}, req_rdy, 0);
    chk({pfx, "_clk_en"},  pipe_clk_en, 1);
    chk({pfx, "_arg_vld"}, pipe_arg_vld, 0);
    chk({pfx, "_arg"},     pipe_arg, 0);
  endtask

  task automatic idle(input int n, input logic [N-1:0] r);
    for (int i = 0; i < n; i++) step('0, '0, r, 1'b0);
  endtask

  task automatic rand_steps(input int n);
    logic [N-1:0]   v, r;
    logic [N*W-1:0] a;
    for (int i = 0; i < n; i++) begin
      v = N'($urandom);
      a = {$urandom};
      for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 3) != 0);
      step(v, a, r, 1'b0);
    end
  endtask

  initial begin
    // power-on reset, requests already pending
    req_vld = '1;
    #3;
    rst_checks("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // single request: requester 2, arg 3 -> 243
    step(4'b0100, pack(0, 0, 3, 0), '1, 1'b0);
    idle(7, '1);

    // round-robin with args 1,2,4,5
    for (int i = 0; i < 12; i++) step('1, pack(1, 2, 4, 5), '1, 1'b0);
    idle(6, '1);

    // backpressure: full pipe, then all ready low for 3 cycles
    for (int i = 0; i < 6; i++) step('1, pack(9, 10, 11, 12), '1, 1'b0);
    for (int i = 0; i < 3; i++) step('1, pack(9, 10, 11, 12), '0, 1'b0);
    idle(8, '1);

    // non-owner ready: requester 1 owns the tail, its ready is low
    step(4'b0010, pack(0, 7, 0, 0), '1, 1'b0);
    idle(8, 4'b1101);
    idle(3, '1);

    // randomized traffic with random backpressure
    rand_steps(400);
    idle(10, '1);

    // error injection on an empty pipeline, then traffic continues
    step('0, '0, '1, 1'b1);
    rand_steps(60);
    idle(10, '1);

    // reset mid-stream with 3 operations in flight
    for (int i = 0; i < 3; i++) step(4'b0100, pack(0, 0, 3 + i, 0), '1, 1'b0);
    rst = 1'b1; req_vld = '0; res_rdy = '1; force_vld = 1'b0;
    #1;
    rst_checks("mid");
    q.delete(); exp_ptr = 0; err_exp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    step('1, pack(21, 22, 23, 24), '1, 1'b0);
    idle(8, '1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
